wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Shares one pipelined Wishbone slave port between two masters: m0 is the core data port, m1 the instruction port.

Interface
REQ-001 Parameter MAX_OUTST, default 4: maximum accepted-but-unacknowledged strobes per grant, range 1..15.
REQ-002 Parameter TIMEOUT, default 255: cycles without ack/err, while outstanding>0, before the arbiter aborts.
REQ-003 clk_i  in  1  single clock; all logic on the rising edge.
REQ-004 reset_i  in  1  synchronous, active-low reset.
REQ-005 mN_cyc_i  in  1  master N bus cycle, N in {0,1}.
REQ-006 mN_stb_i  in  1  master N strobe.
REQ-007 mN_we_i  in  1  master N write enable.
REQ-008 mN_adr_i  in  32  master N byte address.
REQ-009 mN_dat_i  in  32  master N write data.
REQ-010 mN_sel_i  in  4  master N byte select.
REQ-011 mN_stall_o  out  1  stall to master N.
REQ-012 mN_ack_o  out  1  ack to master N.
REQ-013 mN_err_o  out  1  error to master N.
REQ-014 mN_dat_o  out  32  read data to master N, equal to s_dat_i (broadcast).
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
REQ-016 s_adr_o, s_dat_o  out  32 each  slave address and write data.
REQ-017 s_sel_o  out  4  slave byte select.
REQ-018 s_stall_i, s_ack_i, s_err_i  in  1 each  slave stall, ack, error.
REQ-019 s_dat_i  in  32  slave read data.

Function
REQ-020 States: IDLE, GNT0, GNT1, DRAIN; the state is registered.
REQ-021 A master requests when mN_cyc_i & mN_stb_i.
REQ-022 IDLE transitions:
- one requester -> GNTN on the next cycle;
- both requesting -> the master not in last_grant wins (round-robin);
- last_grant resets to 1, so m0 wins the first tie.
REQ-023 In GNTN:
- s_cyc/we/adr/dat/sel_o = master N inputs;
- s_stb_o = mN_stb_i & (outst != MAX_OUTST);
- mN_stall_o = s_stall_i | (outst == MAX_OUTST);
- mN_ack_o/err_o = s_ack_i/s_err_i gated by outst != 0.
REQ-024 The non-granted master, and both masters in IDLE/DRAIN, see stall=1, ack=0, err=0.
REQ-025 outst counter, width 4:
- +1 when s_stb_o & ~s_stall_i;
- -1 on s_ack_i|s_err_i;
- both in the same cycle -> unchanged;
- ack/err with outst=0 -> ignored, not forwarded.
REQ-026 Release occurs when the granted mN_cyc_i=0. Next state:
- other master requesting -> GNT(other);
- otherwise -> IDLE.
- last_grant is updated to N; outst is cleared even if nonzero (Wishbone abort).
REQ-027 Timeout counter:
- counts cycles in GNTN with outst>0 and no s_ack_i/s_err_i;
- clears on any ack/err or on a state change.
REQ-028 When the timeout counter reaches TIMEOUT:
- mN_err_o=1 for exactly that cycle;
- outst cleared; next state DRAIN.
REQ-029 DRAIN lasts exactly one cycle, forcing s_cyc_o=s_stb_o=0; it then goes to IDLE.
REQ-030 Arbitration latency: 1 cycle from a request in IDLE to s_stb_o.
REQ-031 Back-to-back handover: 0 idle cycles between release and the other master's grant.
REQ-032 In IDLE and DRAIN, s_cyc_o=s_stb_o=0; s_adr/dat/sel/we_o are 0.

Reset
REQ-033 While reset_i=0 at a clock edge: state=IDLE, last_grant=1, outst=0, timeout count=0.
REQ-034 Reset output values:
- s_cyc_o=s_stb_o=0;
- all mN_ack_o/err_o=0;
- mN_stall_o=1;
- reset mid-transaction drops s_cyc_o on the following cycle.

Structure
REQ-035 Package wb_arb_pkg holds the state enum (IDLE, GNT0, GNT1, DRAIN) and the MAX_OUTST and TIMEOUT defaults.
REQ-036 Sub-module wb_arb_timer is the timeout counter: inputs enable/clear, output expired pulse, parameterised by TIMEOUT.

Verification
REQ-037 Single master: m0 writes adr 0x100, slave acks after 2 cycles.
- s_stb_o appears 1 cycle after request;
- m0_ack_o pulses once; m1_stall_o=1 throughout.
REQ-038 Tie: both request from reset.
- m0 is granted first;
- on m0 release, m1 is granted on the next cycle with no IDLE cycle;
- on a further tie, m0 is granted.
REQ-039 Pipelining: m1 issues 6 strobes with the slave never stalling and acks delayed 5 cycles.
- the 5th strobe is stalled (outst=4) until the first ack;
- all 6 acks reach m1.
REQ-040 Timeout with TIMEOUT=8: m0 strobe accepted, no ack.
- m0_err_o pulses 8 cycles later;
- one DRAIN cycle with s_cyc_o=0; then IDLE.
- a late s_ack_i in IDLE is not forwarded.
REQ-041 Reset mid-transaction: reset_i=0 while outst=2 under GNT1.
- next cycle: s_cyc_o=0, state IDLE;
- after reset, a tie is granted to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master pipelined Wishbone arbiter.
// No logic here; latency/backpressure live in the arbiter and timer modules.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int DEF_MAX_OUTST = 4;
  localparam int DEF_TIMEOUT   = 255;
  localparam int OUTST_W       = 4;

  function automatic arb_state_e grant_state(input logic master);
    return master ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared slave port.
// slave: arbiter view; master: environment view that drives both masters and the slave.
interface wb_master_arbiter_if;

  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m0_stall_o;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic [31:0] m0_dat_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic        m1_stall_o;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic [31:0] m1_dat_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_stall_i;
  logic        s_ack_i;
  logic        s_err_i;
  logic [31:0] s_dat_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_stall_o, m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_stall_o, m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_stall_i, s_ack_i, s_err_i, s_dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_stall_o, m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_stall_o, m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_stall_i, s_ack_i, s_err_i, s_dat_i
  );

endinterface

// File: rtl/wb_arb_timer.sv
// Watchdog for a stuck slave: counts enabled cycles, pulses expired on the TIMEOUT-th one.
// Expired is combinational in the cycle the limit is hit; clear has priority over enable.
module wb_arb_timer
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // The cycle that would bring the count to TIMEOUT is the expiry cycle itself.
  assign expired = enable & (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between data (m0) and instruction (m1) masters.
// One cycle from request in IDLE to s_stb_o; zero-gap handover; stalls the owner at MAX_OUTST outstanding.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  wb_master_arbiter_if.slave  bus
);

  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);

  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [OUTST_W-1:0] outst_q, outst_d;

  logic req0, req1;
  logic granted, gnt_m;
  logic gnt_cyc, gnt_stb;
  logic full, busy, resp;
  logic stb_out, accept;
  logic tmr_en, tmr_clr, expired;

  assign req0    = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1    = bus.m1_cyc_i & bus.m1_stb_i;
  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign gnt_m   = (state_q == GNT1);
  assign gnt_cyc = gnt_m ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign gnt_stb = gnt_m ? bus.m1_stb_i : bus.m0_stb_i;
  assign full    = (outst_q == OUTST_MAX);
  assign busy    = (outst_q != '0);
  assign resp    = bus.s_ack_i | bus.s_err_i;
  assign stb_out = granted & gnt_stb & ~full;
  assign accept  = stb_out & ~bus.s_stall_i;

  assign tmr_en  = granted & busy & ~resp;
  assign tmr_clr = resp | (state_d != state_q);

  wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_i),
    .rst_n   (reset_i),
    .enable  (tmr_en),
    .clear   (tmr_clr),
    .expired (expired)
  );

  // Read data is broadcast; only the ack qualifies which master consumes it.
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  always_comb begin : bus_mux
    bus.s_cyc_o    = 1'b0;
    bus.s_stb_o    = 1'b0;
    bus.s_we_o     = 1'b0;
    bus.s_adr_o    = '0;
    bus.s_dat_o    = '0;
    bus.s_sel_o    = '0;
    bus.m0_stall_o = 1'b1;
    bus.m0_ack_o   = 1'b0;
    bus.m0_err_o   = 1'b0;
    bus.m1_stall_o = 1'b1;
    bus.m1_ack_o   = 1'b0;
    bus.m1_err_o   = 1'b0;
    if (granted) begin
      bus.s_cyc_o = gnt_cyc;
      bus.s_stb_o = stb_out;
      bus.s_we_o  = gnt_m ? bus.m1_we_i  : bus.m0_we_i;
      bus.s_adr_o = gnt_m ? bus.m1_adr_i : bus.m0_adr_i;
      bus.s_dat_o = gnt_m ? bus.m1_dat_i : bus.m0_dat_i;
      bus.s_sel_o = gnt_m ? bus.m1_sel_i : bus.m0_sel_i;
      // Responses with nothing outstanding are stray and never reach a master.
      if (gnt_m) begin
        bus.m1_stall_o = bus.s_stall_i | full;
        bus.m1_ack_o   = bus.s_ack_i & busy;
        bus.m1_err_o   = (bus.s_err_i & busy) | expired;
      end else begin
        bus.m0_stall_o = bus.s_stall_i | full;
        bus.m0_ack_o   = bus.s_ack_i & busy;
        bus.m0_err_o   = (bus.s_err_i & busy) | expired;
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    outst_d      = outst_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (expired) begin
          state_d = DRAIN;
          outst_d = '0;
        end else if (!gnt_cyc) begin
          // Dropping cyc aborts whatever is still in flight at the slave.
          last_grant_d = gnt_m;
          outst_d      = '0;
          if (gnt_m) begin
            state_d = req0 ? grant_state(1'b0) : IDLE;
          end else begin
            state_d = req1 ? grant_state(1'b1) : IDLE;
          end
        end else begin
          case ({accept, resp & busy})
            2'b10:   outst_d = outst_q + OUTST_W'(1);
            2'b01:   outst_d = outst_q - OUTST_W'(1);
            default: outst_d = outst_q;
          endcase
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      outst_q      <= outst_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: reset, single master, tie/handover, pipelining, timeout, mid-cycle reset.
module tb_wb_master_arbiter;
  import wb_arb_pkg::*;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   ack_cnt;

  logic [15:0] stb_pat;
  logic [15:0] ack_pat;
  logic [15:0] stall_exp;
  logic [15:0] sstb_exp;

  always #5 clk_i = ~clk_i;

  wb_master_arbiter_if bus();

  wb_master_arbiter #(
    .MAX_OUTST (4),
    .TIMEOUT   (8)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
    bus.m0_adr_i = '0;   bus.m0_dat_i = '0;   bus.m0_sel_i = '0;
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m1_adr_i = '0;   bus.m1_dat_i = '0;   bus.m1_sel_i = '0;
    bus.s_stall_i = 1'b0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
    bus.s_dat_i   = '0;
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b0;
    repeat (2) nxt();
    #1;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("rst_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    chk("rst_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    chk("rst_acks_errs", {28'd0, bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}, 32'd0);
    reset_i = 1'b1;
    nxt();

    // Single master write, slave acks two cycles after acceptance.
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1;
    bus.m0_adr_i = 32'h100; bus.m0_dat_i = 32'hDEADBEEF; bus.m0_sel_i = 4'hF;
    ack_cnt = 0;
    #1;
    chk("sm_c0_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("sm_c0_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    ack_cnt += int'(bus.m0_ack_o);
    nxt(); #1;
    chk("sm_c1_s_stb", 32'(bus.s_stb_o), 32'd1);
    chk("sm_c1_s_adr", bus.s_adr_o, 32'h100);
    chk("sm_c1_s_dat", bus.s_dat_o, 32'hDEADBEEF);
    chk("sm_c1_s_we_sel", {27'd0, bus.s_we_o, bus.s_sel_o}, 32'h1F);
    chk("sm_c1_m0_stall", 32'(bus.m0_stall_o), 32'd0);
    chk("sm_c1_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    ack_cnt += int'(bus.m0_ack_o);
    nxt(); bus.m0_stb_i = 1'b0; #1;
    chk("sm_c2_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("sm_c2_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    ack_cnt += int'(bus.m0_ack_o);
    nxt(); bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hCAFEF00D; #1;
    chk("sm_c3_m0_ack", 32'(bus.m0_ack_o), 32'd1);
    chk("sm_c3_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    chk("sm_c3_dat_bcast", bus.m1_dat_o ^ bus.m0_dat_o ^ 32'hCAFEF00D, 32'hCAFEF00D);
    ack_cnt += int'(bus.m0_ack_o);
    nxt(); bus.s_ack_i = 1'b0; bus.m0_cyc_i = 1'b0; #1;
    chk("sm_c4_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    ack_cnt += int'(bus.m0_ack_o);
    chk("sm_ack_count", 32'(ack_cnt), 32'd1);
    nxt(); #1;
    chk("sm_c5_state", 32'(dut.state_q), 32'(IDLE));

    // Tie from reset: m0 first, m1 handed over with no gap, next tie to m0.
    idle_inputs();
    reset_i = 1'b0;
    nxt();
    reset_i = 1'b1;
    nxt();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h200;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h300;
    #1;
    chk("tie_c0_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    nxt(); #1;
    chk("tie_c1_s_adr", bus.s_adr_o, 32'h200);
    chk("tie_c1_m0_stall", 32'(bus.m0_stall_o), 32'd0);
    chk("tie_c1_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    nxt(); bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b1; #1;
    chk("tie_c2_m0_ack", 32'(bus.m0_ack_o), 32'd1);
    chk("tie_c2_m1_ack", 32'(bus.m1_ack_o), 32'd0);
    nxt(); bus.s_ack_i = 1'b0; bus.m0_cyc_i = 1'b0; #1;
    chk("tie_c3_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("tie_c3_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    nxt(); #1;
    chk("tie_c4_s_stb", 32'(bus.s_stb_o), 32'd1);
    chk("tie_c4_s_adr", bus.s_adr_o, 32'h300);
    chk("tie_c4_m1_stall", 32'(bus.m1_stall_o), 32'd0);
    chk("tie_c4_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    nxt(); bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b1; #1;
    chk("tie_c5_m1_ack", 32'(bus.m1_ack_o), 32'd1);
    chk("tie_c5_m0_ack", 32'(bus.m0_ack_o), 32'd0);
    nxt(); bus.s_ack_i = 1'b0; bus.m1_cyc_i = 1'b0; #1;
    nxt(); #1;
    chk("tie_c7_state", 32'(dut.state_q), 32'(IDLE));
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    nxt(); #1;
    chk("tie_c8_s_adr", bus.s_adr_o, 32'h200);
    chk("tie_c8_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    nxt(); idle_inputs(); #1;
    nxt();

    // m1 pipelines six reads, slave never stalls, acks five cycles after acceptance.
    stb_pat   = 16'b0000_0001_1111_1111;
    ack_pat   = 16'b0011_0011_1100_0000;
    stall_exp = 16'b0000_0000_0110_0001;
    sstb_exp  = 16'b0000_0001_1001_1110;
    ack_cnt   = 0;
    bus.m1_cyc_i = 1'b1; bus.m1_adr_i = 32'h400;
    for (int c = 0; c < 14; c++) begin
      bus.m1_stb_i = stb_pat[c];
      bus.s_ack_i  = ack_pat[c];
      #1;
      chk($sformatf("pipe_c%0d_m1_stall", c), 32'(bus.m1_stall_o), 32'(stall_exp[c]));
      chk($sformatf("pipe_c%0d_s_stb", c), 32'(bus.s_stb_o), 32'(sstb_exp[c]));
      chk($sformatf("pipe_c%0d_m1_ack", c), 32'(bus.m1_ack_o), 32'(ack_pat[c]));
      if (c == 5) chk("pipe_c5_outst", 32'(dut.outst_q), 32'd4);
      ack_cnt += int'(bus.m1_ack_o);
      nxt();
    end
    bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_cyc_i = 1'b0;
    #1;
    chk("pipe_ack_count", 32'(ack_cnt), 32'd6);
    nxt();

    // Timeout: one accepted strobe never answered.
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h500; bus.m0_we_i = 1'b1;
    #1;
    nxt(); #1;
    chk("to_c1_s_stb", 32'(bus.s_stb_o), 32'd1);
    nxt(); bus.m0_stb_i = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      #1;
      chk($sformatf("to_c%0d_m0_err", c), 32'(bus.m0_err_o), 32'd0);
      nxt();
    end
    #1;
    chk("to_c9_m0_err", 32'(bus.m0_err_o), 32'd1);
    chk("to_c9_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    nxt(); #1;
    chk("to_c10_state", 32'(dut.state_q), 32'(DRAIN));
    chk("to_c10_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("to_c10_m0_err", 32'(bus.m0_err_o), 32'd0);
    nxt(); bus.s_ack_i = 1'b1; #1;
    chk("to_c11_state", 32'(dut.state_q), 32'(IDLE));
    chk("to_c11_late_ack", {30'd0, bus.m0_ack_o, bus.m1_ack_o}, 32'd0);
    nxt(); bus.s_ack_i = 1'b0; bus.m0_cyc_i = 1'b0; bus.m0_we_i = 1'b0; #1;
    chk("to_c12_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    nxt();

    // Reset mid-transaction with two outstanding under GNT1, after m0 held last grant.
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h600;
    #1;
    nxt(); #1;
    nxt();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h700;
    #1;
    chk("rm_c2_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    nxt(); #1;
    chk("rm_c3_outst_abort", 32'(dut.outst_q), 32'd0);
    chk("rm_c3_s_adr", bus.s_adr_o, 32'h700);
    nxt(); #1;
    nxt(); bus.m1_stb_i = 1'b0; reset_i = 1'b0; #1;
    chk("rm_c5_outst", 32'(dut.outst_q), 32'd2);
    chk("rm_c5_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    nxt();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
    #1;
    chk("rm_c6_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rm_c6_state", 32'(dut.state_q), 32'(IDLE));
    chk("rm_c6_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    nxt(); reset_i = 1'b1; #1;
    chk("rm_c7_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    nxt(); #1;
    chk("rm_c8_s_adr", bus.s_adr_o, 32'h600);
    chk("rm_c8_m0_stall", 32'(bus.m0_stall_o), 32'd0);
    chk("rm_c8_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    idle_inputs();
    repeat (2) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
